// File: rtl/rotate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rotate_arbiter
//  Brief    : Round-robin arbiter that shares one barrel rotator between
//             NUM_REQ valid/ready requesters. Results come back on a single
//             registered valid/ready port, tagged with the requester index.
//  Options  : ROTATE_ARB_PIPE_EN adds a register stage (s1) between the
//             arbiter and the rotator. Latency becomes 2, throughput stays 1.
//  Revision : 1.0 - initial release
// ============================================================================
module rotate_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]           req_data,
    input  logic [NUM_REQ*$clog2(WIDTH)-1:0]   req_shift,
    input  logic [NUM_REQ-1:0]                 req_dir,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic [$clog2(NUM_REQ)-1:0]         out_id
);

    localparam int SW = $clog2(WIDTH);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW:0]   c_num_req = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] c_last_id = IW'(NUM_REQ - 1);

    logic [IW-1:0]    r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [IW-1:0]    r_out_id;

    logic             w_can_accept;
    logic             w_found;
    logic [IW-1:0]    w_winner;
    logic [IW:0]      w_sum;
    logic             w_xfer;

    logic [WIDTH-1:0] w_data_arr  [NUM_REQ];
    logic [SW-1:0]    w_shift_arr [NUM_REQ];

    logic [WIDTH-1:0] w_rot_in;
    logic [SW-1:0]    w_rot_shift;
    logic             w_rot_dir;
    logic [IW-1:0]    w_rot_id;
    logic [SW-1:0]    w_rot_amt;
    logic [WIDTH-1:0] w_rot_out;
    logic             w_out_load;

    // Split the packed request buses into per-requester words
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_data_arr[i]  = req_data[i*WIDTH +: WIDTH];
            assign w_shift_arr[i] = req_shift[i*SW +: SW];
        end
    endgenerate

    // Round-robin search: first valid requester at or after the pointer
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= c_num_req) begin
                w_sum = w_sum - c_num_req;
            end
            if (!w_found && req_valid[w_sum[IW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IW-1:0];
            end
        end
    end

    assign w_xfer = w_found && w_can_accept;

    // Grant is one-hot on the winner and only when the next stage can take it
    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    // Priority pointer moves just past the requester that transferred
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_winner == c_last_id) ? '0 : w_winner + IW'(1);
        end
    end

`ifdef ROTATE_ARB_PIPE_EN
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [SW-1:0]    r_s1_shift;
    logic             r_s1_dir;
    logic [IW-1:0]    r_s1_id;
    logic             w_s1_adv;

    assign w_s1_adv     = r_s1_valid && (!r_out_valid || out_ready);
    assign w_can_accept = !r_s1_valid || w_s1_adv;
    assign w_out_load   = w_s1_adv;
    assign w_rot_in     = r_s1_data;
    assign w_rot_shift  = r_s1_shift;
    assign w_rot_dir    = r_s1_dir;
    assign w_rot_id     = r_s1_id;

    // s1 captures the granted request and empties when it moves on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_shift <= '0;
            r_s1_dir   <= 1'b0;
            r_s1_id    <= '0;
        end else if (w_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= w_data_arr[w_winner];
            r_s1_shift <= w_shift_arr[w_winner];
            r_s1_dir   <= req_dir[w_winner];
            r_s1_id    <= w_winner;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end
`else
    assign w_can_accept = !r_out_valid || out_ready;
    assign w_out_load   = w_xfer;
    assign w_rot_in     = w_data_arr[w_winner];
    assign w_rot_shift  = w_shift_arr[w_winner];
    assign w_rot_dir    = req_dir[w_winner];
    assign w_rot_id     = w_winner;
`endif

    // Barrel rotator: right by s is left by (-s mod WIDTH)
    always_comb begin
        w_rot_amt = w_rot_dir ? (SW'(0) - w_rot_shift) : w_rot_shift;
        w_rot_out = (w_rot_in << w_rot_amt) | (w_rot_in >> (WIDTH - int'(w_rot_amt)));
    end

    // Output register: load a new result, otherwise drop valid once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
        end else if (w_out_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_rot_out;
            r_out_id    <= w_rot_id;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule
`default_nettype wire

// File: tb/tb_rotate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rotate_arbiter
//  Brief    : Directed self-checking bench for rotate_arbiter (WIDTH=8,
//             NUM_REQ=4). Latency-aware for the ROTATE_ARB_PIPE_EN build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rotate_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
`ifdef ROTATE_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_data = '0;
    logic [NUM_REQ*3-1:0] req_shift = '0;
    logic [NUM_REQ-1:0]   req_dir = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [7:0]           out_data;
    logic [1:0]           out_id;

    int tests_run = 0;
    int tests_failed = 0;

    rotate_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shift (req_shift),
        .req_dir   (req_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Present one request for one cycle, return after its result is visible
    task automatic issue(input int idx, input logic [7:0] d, input logic [2:0] s, input logic dir);
        req_valid = '0;
        req_data[idx*8 +: 8] = d;
        req_shift[idx*3 +: 3] = s;
        req_dir[idx] = dir;
        req_valid[idx] = 1'b1;
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (LAT-1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        #2;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests_run++;
        if (out_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_out_data: got %h expected 00", out_data);
        end
        tests_run++;
        if (out_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_out_id: got %0d expected 0", out_id);
        end
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_rotate_left();
        do_reset();
        req_valid = 4'b0001;
        req_data[7:0] = 8'h81;
        req_shift[2:0] = 3'd1;
        req_dir[0] = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL left_ready: got %b expected 0001", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (LAT-1) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h03 || out_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL left_result: got v=%b d=%h id=%0d expected v=1 d=03 id=0",
                     out_valid, out_data, out_id);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL left_single_cycle: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_rotate_right();
        out_ready = 1'b1;
        issue(2, 8'h81, 3'd1, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'hC0 || out_id !== 2'd2) begin
            tests_failed++;
            $display("FAIL right_1: got v=%b d=%h id=%0d expected v=1 d=c0 id=2",
                     out_valid, out_data, out_id);
        end
        issue(2, 8'h5A, 3'd0, 1'b1);
        tests_run++;
        if (out_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL right_zero: got %h expected 5a", out_data);
        end
        issue(2, 8'h01, 3'd7, 1'b1);
        tests_run++;
        if (out_data !== 8'h02) begin
            tests_failed++;
            $display("FAIL right_7: got %h expected 02", out_data);
        end
        issue(1, 8'h01, 3'd7, 1'b0);
        tests_run++;
        if (out_data !== 8'h80 || out_id !== 2'd1) begin
            tests_failed++;
            $display("FAIL left_7: got d=%h id=%0d expected d=80 id=1", out_data, out_id);
        end
        issue(3, 8'hA5, 3'd0, 1'b0);
        tests_run++;
        if (out_data !== 8'hA5 || out_id !== 2'd3) begin
            tests_failed++;
            $display("FAIL left_zero: got d=%h id=%0d expected d=a5 id=3", out_data, out_id);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*8 +: 8] = 8'h10 + 8'(i);
            req_shift[i*3 +: 3] = 3'd0;
            req_dir[i] = 1'b0;
        end
        out_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL fair_ready_0: got %b expected 0001", req_ready);
        end
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (req_ready !== (4'b0001 << (e % 4))) begin
                tests_failed++;
                $display("FAIL fair_ready_%0d: got %b expected %b", e, req_ready,
                         4'b0001 << (e % 4));
            end
            tests_run++;
            if (e < LAT) begin
                if (out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL fair_early_%0d: got out_valid=%b expected 0", e, out_valid);
                end
            end else if (out_valid !== 1'b1 || out_id !== 2'((e - LAT) % 4) ||
                         out_data !== 8'h10 + 8'((e - LAT) % 4)) begin
                tests_failed++;
                $display("FAIL fair_out_%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h",
                         e, out_valid, out_id, out_data, (e - LAT) % 4, 8'h10 + 8'((e - LAT) % 4));
            end
        end
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

`ifndef ROTATE_ARB_PIPE_EN
    task automatic test_backpressure();
        do_reset();
        req_data  = {8'h80, 8'h0F, 8'h81, 8'h01};
        req_shift = {3'd1,  3'd4,  3'd2,  3'd0};
        req_dir   = 4'b0100;
        out_ready = 1'b1;
        req_valid = 4'b0010;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 8'h06 || out_id !== 2'd1) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: got v=%b d=%h id=%0d expected v=1 d=06 id=1",
                         c, out_valid, out_data, out_id);
            end
            tests_run++;
            if (req_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_ready_%0d: got %b expected 0000", c, req_ready);
            end
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL bp_resume_ready: got %b expected 0100", req_ready);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'hF0 || out_id !== 2'd2) begin
            tests_failed++;
            $display("FAIL bp_resume_out: got v=%b d=%h id=%0d expected v=1 d=f0 id=2",
                     out_valid, out_data, out_id);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_data !== 8'h01 || out_id !== 2'd3) begin
            tests_failed++;
            $display("FAIL bp_next_out: got d=%h id=%0d expected d=01 id=3", out_data, out_id);
        end
        req_valid = '0;
        @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL rstmid_async: got v=%b d=%h id=%0d expected v=0 d=00 id=0",
                     out_valid, out_data, out_id);
        end
        req_valid = 4'b1001;
        #1;
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_no_output: got out_valid=%b expected 0", out_valid);
        end
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rstmid_first_grant: got %b expected 0001", req_ready);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (req_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL rstmid_second_grant: got %b expected 1000", req_ready);
        end
        req_valid = '0;
        repeat (LAT-1) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL rstmid_out: got v=%b id=%0d expected v=1 id=0", out_valid, out_id);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_rotate_left();
        test_rotate_right();
        test_fairness();
`ifndef ROTATE_ARB_PIPE_EN
        test_backpressure();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
